// File: rtl/instr_sequencer_if.sv
// ----------------------------------------------------------------------------
// instr_sequencer_if
// Sequencer <-> CPU handshake bundle.
//   master : the sequencer; drives run and the din word, watches CPU strobes.
//   slave  : the CPU; consumes run/din, drives ir_en, din_en, done, dout_en
//            and presents cpu_bus alongside dout_en.
// Signals:
//   run      CPU run enable
//   din      word presented to the CPU (mem[pc])
//   ir_en    CPU fetch strobe (current word consumed as an instruction)
//   din_en   CPU immediate strobe (current word consumed as MVI data)
//   done     CPU instruction-complete strobe
//   dout_en  CPU output strobe
//   cpu_bus  CPU bus value, valid while dout_en=1
// ----------------------------------------------------------------------------
interface instr_sequencer_if #(
    parameter int unsigned DW = 9
);
    logic          run;
    logic [DW-1:0] din;
    logic          ir_en;
    logic          din_en;
    logic          done;
    logic          dout_en;
    logic [DW-1:0] cpu_bus;

    modport master (
        output run,
        output din,
        input  ir_en,
        input  din_en,
        input  done,
        input  dout_en,
        input  cpu_bus
    );

    modport slave (
        input  run,
        input  din,
        output ir_en,
        output din_en,
        output done,
        output dout_en,
        output cpu_bus
    );
endinterface

// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
// Program-side partner of the CPU control unit. Holds a DEPTH x 9-bit program,
// presents mem[pc] to the CPU, and advances pc on the CPU's fetch/immediate
// strobes. A word whose opcode field equals HALT_OP ends the program without
// ever being handed to the CPU. Output words written by the CPU are captured.
//
// Optional feature macro: SEQ_SINGLE_STEP_EN
//   Adds step_mode/step inputs and a PAUSE state: with step_mode=1 every
//   completed instruction parks the sequencer in PAUSE until a step pulse.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   load_en      program write strobe (honoured in IDLE and HALT only)
//   load_addr    program write address
//   load_data    program word
//   start        begin execution from address 0 (ignored while running)
//   step_mode    (SEQ_SINGLE_STEP_EN) pause after each completed instruction
//   step         (SEQ_SINGLE_STEP_EN) resume from PAUSE
//   cpu          handshake bundle (run, din, ir_en, din_en, done, dout_en,
//                cpu_bus); run and din are combinational
//   pc           current program address
//   busy         high in RUN (and PAUSE)
//   halted       high in HALT
//   out_valid    one-cycle pulse per captured output word
//   out_data     last captured output word
//   instr_count  completed instructions since start, saturating
// ----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned AW      = 5,
    parameter logic [2:0]  HALT_OP = 3'b111
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic [AW-1:0]        load_addr,
    input  logic [8:0]           load_data,
    input  logic                 start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                 step_mode,
    input  logic                 step,
`endif
    instr_sequencer_if.master    cpu,
    output logic [AW-1:0]        pc,
    output logic                 busy,
    output logic                 halted,
    output logic                 out_valid,
    output logic [8:0]           out_data,
    output logic [15:0]          instr_count
);

    localparam int unsigned WW = 9;
    localparam int unsigned CW = 16;

`ifdef SEQ_SINGLE_STEP_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_PAUSE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;
`endif

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   pc_d;
    logic [CW-1:0]   count_d;
    logic            mem_we;
    logic            run_c;
    logic            strobe_any;
    logic            halt_hit;
    logic [WW-1:0]   din_c;
    logic [WW-1:0]   mem [DEPTH];

    // Program store: write-only from the loader, no reset so a program
    // survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    assign din_c   = mem[pc];
    assign cpu.din = din_c;
    assign cpu.run = run_c;

    // Any CPU activity this cycle means the current word is still in use,
    // so a halt opcode is only acted on in a quiet cycle.
    assign strobe_any = cpu.ir_en | cpu.din_en | cpu.done | cpu.dout_en;
    assign halt_hit   = (state_q == S_RUN) && (din_c[8:6] == HALT_OP) && !strobe_any;

    // Next-state, pc/count update and combinational run.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        count_d = instr_count;
        mem_we  = 1'b0;
        run_c   = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                mem_we = load_en;
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    count_d = '0;
                end
            end

            S_RUN: begin
                // run drops in the detection cycle so the CPU never fetches the halt word
                run_c = !halt_hit;
                if (halt_hit) begin
                    state_d = S_HALT;
                end else begin
                    // DEPTH == 2**AW, so the natural AW-bit rollover gives the wrap
                    if (cpu.ir_en || cpu.din_en) begin
                        pc_d = pc + AW'(1);
                    end
                    if (cpu.done && (instr_count != {CW{1'b1}})) begin
                        count_d = instr_count + CW'(1);
                    end
`ifdef SEQ_SINGLE_STEP_EN
                    if (step_mode && cpu.done) begin
                        state_d = S_PAUSE;
                    end
`endif
                end
            end

`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (step) begin
                    state_d = S_RUN;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered status/output capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc          <= '0;
            instr_count <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            instr_count <= count_d;
`ifdef SEQ_SINGLE_STEP_EN
            busy        <= (state_d == S_RUN) || (state_d == S_PAUSE);
`else
            busy        <= (state_d == S_RUN);
`endif
            halted      <= (state_d == S_HALT);
            out_valid   <= cpu.dout_en;
            if (cpu.dout_en) begin
                out_data <= cpu.cpu_bus;
            end
        end
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program-side partner of the CPU control unit. It stores a 9-bit program and feeds the CPU.
- Drives `run` and the `din` word.
- Tracks the CPU's `ir_en`, `din_en` and `done` strobes to advance its program counter, including MVI immediates.
- Captures CPU output words on `dout_en`.
- Sits between a loader/testbench and the CPU datapath at top level.

Parameters:
- DEPTH, 32, number of 9-bit program words.
- AW, 5, address width; DEPTH must equal 2**AW.
- HALT_OP, 3'b111, opcode field value that the sequencer treats as end of program. The CPU never receives it.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_en  input  1  write load_data into program memory at load_addr; accepted only in IDLE or HALT.
- load_addr  input  AW  program write address.
- load_data  input  9  program word.
- start  input  1  one-cycle pulse; begins execution from address 0.
- ir_en  input  1  CPU fetch strobe; the current word is consumed as an instruction.
- din_en  input  1  CPU immediate strobe; the current word is consumed as MVI data.
- done  input  1  CPU instruction-complete strobe.
- dout_en  input  1  CPU output strobe.
- cpu_bus  input  9  CPU bus value, valid while dout_en=1.
- din  output  9  word presented to the CPU; combinational mem[pc].
- run  output  1  CPU run enable.
- pc  output  AW  current program address.
- busy  output  1  high in RUN.
- halted  output  1  high in HALT.
- out_valid  output  1  one-cycle pulse per captured output word.
- out_data  output  9  last captured output word.
- instr_count  output  16  completed instructions since start; saturates at 16'hFFFF.

Behaviour:
- Reset values: pc=0, run=0, busy=0, halted=0, out_valid=0, out_data=0, instr_count=0, state=IDLE.
- Program memory is not reset.
- States and transitions:
  - IDLE: run=0. On start go to RUN, with pc=0 and instr_count=0.
  - RUN: run=1 and busy=1, except as stated under halt detection.
  - HALT: run=0, halted=1. On start re-enter RUN, with pc=0 and instr_count=0, and clear halted.
- Halt detection: in RUN, when din[8:6]==HALT_OP and no CPU strobe is active, the sequencer enters HALT at the next edge.
  - run is forced to 0 combinationally in that same cycle, so the CPU never fetches HALT_OP.
  - pc stays pointing at the halt word.
- pc advance: in RUN, pc increments by 1 on each edge where ir_en=1 or din_en=1.
  - ir_en and din_en are never both 1. If they are, pc advances by 1 only.
  - Wrap: pc=DEPTH-1 advances to 0.
- MVI flow: fetch cycle ir_en=1 gives pc+1, so din then presents the immediate. The next cycle din_en=1 gives pc+1 again.
- instr_count: increments on each edge with done=1 in RUN.
- Output capture: on an edge with dout_en=1, in any state, out_data<=cpu_bus and out_valid=1 for exactly one cycle. Otherwise out_valid=0.
- load_en in RUN is ignored, with no memory write.
- load_en in IDLE or HALT writes on the edge. din reflects the new word in the next cycle if load_addr==pc.
- start while in RUN is ignored.
- Asynchronous reset mid-program: all outputs return to reset values immediately, run drops, and program memory contents are retained.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined, the block adds two input ports, `step_mode` (1 bit) and `step` (1-bit pulse), and adds a PAUSE state.
  - In RUN with step_mode=1, an edge with done=1 moves the block to PAUSE. PAUSE has run=0 and busy=1.
  - A step pulse returns the block from PAUSE to RUN.
  - Halt detection still applies on re-entry to RUN.
- When undefined, the ports and the PAUSE state do not exist and execution is free-running.

Test Plan:
- Load mem[0]=MVI r0 (9'o100), mem[1]=9'd5, mem[2]=MVO r0 (9'o400), mem[3]=9'o700; pulse start; emulate the CPU strobe sequence.
  - Required: pc steps 0→1→2→3.
  - Required: out_valid pulses once with out_data=5.
  - Required: HALT is entered with run=0 and instr_count=2.
- Halt at address 0: mem[0]=9'o700, then start.
  - Required: run stays 0 on every cycle.
  - Required: halted=1 after 1 cycle; pc=0; ir_en never needed.
- Wrap: fill memory with MV (9'o000), no halt word. Drive 33 fetch/done pairs.
  - Required: pc goes 31→0→1.
  - Required: instr_count=33.
- Load during RUN: assert load_en at address 5 with data 9'o700 while busy.
  - Required: the memory word is unchanged, checked after halt via din.
- Reset mid-run: assert reset while pc=3 and busy=1.
  - Required: all outputs are 0 immediately.
  - Required: start then re-runs the retained program from pc=0.
- With SEQ_SINGLE_STEP_EN, step_mode=1, program MV, MV, halt.
  - Required: run drops after each done.
  - Required: each step pulse resumes run; halted after the 2nd step.
